// File: rtl/keypad_scanner_db.sv
// keypad_scanner_db: scans an NCOL x NROW switch matrix and reports debounced key events
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   col_drv     one-cold column drive
//   row_in      active-low row sense, asynchronous to clk
//   key_code    last accepted key, col*NROW + row
//   key_valid   one-cycle pulse on an accepted press
//   key_held    level, accepted key still pressed
//   key_release one-cycle pulse on a debounced release
//   multi_err   one-cycle pulse when a sample shows several rows low
module keypad_scanner_db #(
  parameter int NCOL = 4,
  parameter int NROW = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  localparam int KEY_W = $clog2(NCOL * NROW)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [NCOL-1:0]  col_drv,
  input  logic [NROW-1:0]  row_in,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held,
  output logic             key_release,
  output logic             multi_err
);
  localparam int CW = $clog2(NCOL);
  localparam int RW = $clog2(NROW);
  localparam int DW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {SCAN, PRESS_DB, HOLD} state_t;
  state_t state;
  logic [NROW-1:0] sync1, row_s, low;
  logic [DW-1:0] dwell;
  logic [CW-1:0] col;
  logic [RW-1:0] r, cand_row;
  logic [7:0] deb_cnt, rel_cnt;
  logic last, none, one, multi, stay_pd, accept, rel_done, adv;
  logic [KEY_W-1:0] code_now;
  assign last = dwell == DW'(SCAN_DIV - 1);
  assign low = ~row_s;
  assign none = low == '0;
  // exactly one bit set <=> nonzero power of two
  assign one = !none && ((low & (low - NROW'(1))) == '0);
  assign multi = !none && !one;
  always_comb begin
    r = '0;
    for (int i = 0; i < NROW; i++)
      if (low[i]) r = RW'(i);
  end
  assign stay_pd = one && r == cand_row;
  assign rel_done = none && rel_cnt + 8'd1 == 8'(DEBOUNCE);
  assign accept = last && one && ((state == SCAN && DEBOUNCE == 1) ||
                  (state == PRESS_DB && stay_pd && deb_cnt + 8'd1 == 8'(DEBOUNCE)));
  assign adv = last && ((state == SCAN && !one) || (state == PRESS_DB && !stay_pd) ||
               (state == HOLD && rel_done));
  // the column is held while debouncing, so the live column is the candidate column
  assign code_now = KEY_W'(col) * KEY_W'(NROW) + KEY_W'(r);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SCAN;
      sync1 <= '1;
      row_s <= '1;
      dwell <= '0;
      col <= '0;
      col_drv <= {{(NCOL-1){1'b1}}, 1'b0};
      cand_row <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
      key_release <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      sync1 <= row_in;
      row_s <= sync1;
      dwell <= last ? '0 : dwell + DW'(1);
      key_valid <= 1'b0;
      key_release <= 1'b0;
      multi_err <= 1'b0;
      if (adv) begin
        col <= col == CW'(NCOL - 1) ? '0 : col + CW'(1);
        col_drv <= {col_drv[NCOL-2:0], col_drv[NCOL-1]};
      end
      if (last)
        case (state)
          SCAN: begin
            multi_err <= multi;
            if (one) begin
              cand_row <= r;
              deb_cnt <= 8'd1;
              state <= PRESS_DB;
            end
          end
          PRESS_DB: begin
            deb_cnt <= stay_pd ? deb_cnt + 8'd1 : 8'd0;
            if (!stay_pd) state <= SCAN;
          end
          HOLD: begin
            rel_cnt <= (none && !rel_done) ? rel_cnt + 8'd1 : 8'd0;
            if (rel_done) begin
              key_release <= 1'b1;
              key_held <= 1'b0;
              state <= SCAN;
            end
          end
          default: state <= SCAN;
        endcase
      if (accept) begin
        key_code <= code_now;
        key_valid <= 1'b1;
        key_held <= 1'b1;
        deb_cnt <= '0;
        state <= HOLD;
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner_db.sv
// tb_keypad_scanner_db: directed bench for keypad_scanner_db with a modelled 4x4 key matrix
module tb_keypad_scanner_db;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] col_drv, row_in, key_code;
  logic key_valid, key_held, key_release, multi_err;
  logic [15:0] pressed = '0;
  int vectors = 0, fails = 0;
  int n_valid = 0, n_rel = 0, n_multi = 0, n_overlap = 0;
  int n, v0, m0, r0;
  logic [3:0] prev;
  logic [3:0] seq [4] = '{4'hD, 4'hB, 4'h7, 4'hE};

  always #5 clk = ~clk;

  keypad_scanner_db #(.NCOL(4), .NROW(4), .SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .rst(rst), .col_drv(col_drv), .row_in(row_in), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .key_release(key_release), .multi_err(multi_err)
  );

  always_comb begin
    row_in = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !col_drv[c]) row_in[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) n_valid++;
    if (key_release === 1'b1) n_rel++;
    if (multi_err === 1'b1) n_multi++;
    if (int'(key_valid) + int'(key_release) + int'(multi_err) > 1) n_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) step;
    chk("rst_col", 32'(col_drv), 32'hE);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    chk("rst_rel", 32'(key_release), 32'h0);
    chk("rst_multi", 32'(multi_err), 32'h0);
    rst = 1'b1;
    prev = 4'hE;
    for (int k = 0; k < 4; k++) begin
      repeat (3) step;
      chk("dwell", 32'(col_drv), 32'(prev));
      step;
      chk("col_adv", 32'(col_drv), 32'(seq[k]));
      prev = seq[k];
    end
    chk("idle_pulses", 32'(n_valid + n_rel + n_multi), 32'h0);
    chk("idle_code", 32'(key_code), 32'h0);

    pressed[9] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 100) begin step; n++; end
    chk("press_lat", 32'(n), 32'd20);
    chk("press_code", 32'(key_code), 32'h9);
    chk("press_held", 32'(key_held), 32'h1);
    chk("press_col", 32'(col_drv), 32'hB);
    step;
    chk("valid_width", 32'(key_valid), 32'h0);
    chk("valid_count", 32'(n_valid), 32'h1);

    pressed[9] = 1'b0;
    n = 0;
    while (key_release !== 1'b1 && n < 100) begin step; n++; end
    chk("rel_lat", 32'(n), 32'd11);
    chk("rel_held", 32'(key_held), 32'h0);
    chk("rel_code", 32'(key_code), 32'h9);
    chk("rel_col", 32'(col_drv), 32'h7);
    step;
    chk("rel_width", 32'(key_release), 32'h0);

    v0 = n_valid;
    pressed[2] = 1'b1;
    repeat (11) step;
    chk("bounce_hold", 32'(col_drv), 32'hE);
    pressed[2] = 1'b0;
    repeat (4) step;
    chk("bounce_adv", 32'(col_drv), 32'hD);
    chk("bounce_valid", 32'(n_valid - v0), 32'h0);
    chk("bounce_held", 32'(key_held), 32'h0);

    m0 = n_multi;
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    repeat (4) step;
    chk("multi_1", 32'(multi_err), 32'h1);
    chk("multi_adv", 32'(col_drv), 32'hB);
    step;
    chk("multi_width", 32'(multi_err), 32'h0);
    repeat (15) step;
    chk("multi_2", 32'(multi_err), 32'h1);
    step;
    chk("multi_count", 32'(n_multi - m0), 32'h2);
    chk("multi_valid", 32'(n_valid - v0), 32'h0);

    pressed[4] = 1'b0;
    pressed[7] = 1'b0;
    pressed[15] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 100) begin step; n++; end
    chk("k15_lat", 32'(n), 32'd15);
    chk("k15_code", 32'(key_code), 32'hF);
    repeat (6) step;
    chk("k15_held", 32'(key_held), 32'h1);
    r0 = n_rel;
    #2 rst = 1'b0;
    #1;
    chk("arst_col", 32'(col_drv), 32'hE);
    chk("arst_code", 32'(key_code), 32'h0);
    chk("arst_held", 32'(key_held), 32'h0);
    chk("arst_valid", 32'(key_valid), 32'h0);
    pressed[15] = 1'b0;
    repeat (3) step;
    rst = 1'b1;
    repeat (20) step;
    chk("arst_norel", 32'(n_rel - r0), 32'h0);
    chk("no_overlap", 32'(n_overlap), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/keypad_scanner_db.md
Name: keypad_scanner_db

Overview:
Parametrised matrix-keypad scanner with debounce, for an NCOL x NROW switch matrix (default 4x4).
- Drives one column low at a time and samples the active-low row lines through a 2-FF synchroniser.
- Debounces a single pressed key, then reports press, hold and release events to downstream logic (display/entry controllers).
- Flags simultaneous multi-key presses instead of reporting a wrong code.

Parameters:
NCOL, 4, number of column drive lines (>=2)
NROW, 4, number of row sense lines (>=2)
SCAN_DIV, 1000, clk cycles each column is driven per scan step (>=4, covers synchroniser latency)
DEBOUNCE, 4, consecutive identical samples required to accept a press or a release (>=1, <=255)
KEY_W, $clog2(NCOL*NROW), width of key code (derived localparam, not overridable)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
col_drv  out  NCOL  column drive, one-cold (exactly one bit 0)
row_in  in  NROW  row sense, active-low, asynchronous to clk
key_code  out  KEY_W  code of last accepted key = col*NROW + row
key_valid  out  1  one-cycle pulse: debounced press accepted
key_held  out  1  level: accepted key still pressed
key_release  out  1  one-cycle pulse: debounced release of held key
multi_err  out  1  one-cycle pulse: more than one row low in one sample

Behaviour:
- Reset (rst=0, async): col_drv=~1 (column 0 driven), key_code=0, key_valid=0, key_held=0, key_release=0, multi_err=0, state=SCAN, dwell counter=0, debounce counter=0, synchroniser=all 1s.
- Row synchroniser: two flops; row_s is row_in delayed 2 clk.
- Dwell counter: counts 0..SCAN_DIV-1 continuously, wraps to 0.
- Sample point: the cycle with counter==SCAN_DIV-1. row_s is evaluated only at sample points.
- Column advance: occurs only at a sample point, only when the FSM says advance. Order is 0,1,...,NCOL-1, then wraps to 0.
- Sample classification: NONE (all 1), ONE (exactly one 0, row index r), MULTI (>=2 zeros).

FSM states:
- SCAN:
  - NONE -> advance column.
  - MULTI -> multi_err pulse next cycle, advance column.
  - ONE -> latch cand_col = current column, cand_row = r, deb_cnt = 1, hold column, go PRESS_DB. If DEBOUNCE==1, accept immediately (see PRESS_DB).
- PRESS_DB: column held.
  - ONE with same r -> deb_cnt++. On reaching DEBOUNCE: key_code = cand_col*NROW + cand_row, key_valid = 1 for exactly one cycle, key_held = 1, go HOLD.
  - Any other sample (NONE, MULTI, different r) -> deb_cnt = 0, advance column, go SCAN. No outputs change.
- HOLD: column held, key_held = 1.
  - NONE -> rel_cnt++. On reaching DEBOUNCE: key_release = 1 for one cycle, key_held = 0, rel_cnt = 0, advance column, go SCAN.
  - Any non-NONE sample -> rel_cnt = 0 and stay in HOLD. Additional keys pressed in the held column are ignored, with no multi_err. Keys in other columns are invisible while holding.
- key_code holds its value until the next accepted press; it is not cleared on release.
- Output timing: key_valid, key_release and multi_err are registered, asserted the cycle after the deciding sample point. They never overlap.
- Latency, clean press on column c: key_valid rises 1 clk after the DEBOUNCE-th consecutive sample of that column. Minimum is (DEBOUNCE-1)*SCAN_DIV + 1 clk after the first detecting sample.
- Reset mid-operation: all state and outputs return to reset values immediately. No key_release is emitted for a key held at reset.
- Counter widths: dwell counter is $clog2(SCAN_DIV) bits; debounce/release counters are 8 bits. Saturation is not needed because the DEBOUNCE <= 255 limit keeps them in range.

Test Plan:
(All with NCOL=4, NROW=4, SCAN_DIV=4, DEBOUNCE=3.)
- Reset/idle: rst low then high, no keys -> col_drv cycles 1110, 1101, 1011, 0111, 1110, each for 4 clk; all pulses stay 0; key_code = 0.
- Clean press of col 2 / row 1 (row_in=1101 whenever col_drv=1011):
  - col_drv freezes at 1011.
  - key_valid is one 1-cycle pulse with key_code = 9, 2*4+4*... i.e. 2*4+1 = 9 (4'b1001), after the 3rd matching sample.
  - key_held = 1.
- Release after that press: row_in=1111 -> key_release pulses after 3 NONE samples; key_held = 0; key_code stays 9; scanning resumes at col_drv=0111.
- Bounce: row_in low for 2 samples then high before the 3rd -> no key_valid; scanning advances to the next column.
- Multi-key: rows 0 and 3 low together on column 1 while in SCAN -> multi_err pulses once per such sample; key_valid stays 0.
- Async reset asserted during HOLD of key 15 -> outputs return to reset values in the same cycle; key_release is never pulsed.
